// File: rtl/render_scheduler_if.sv
// Signal bundle between the render scheduler, the two draw engines, the CPU and the frame buffer.
// The master side is the scheduler; the slave side is everything it sequences and arbitrates.
interface render_scheduler_if #(
    parameter int unsigned FC_W = 16,
    parameter int unsigned OV_W = 8
);
    logic            frame_start;
    logic            sprites_en;
    logic            cpu_req;
    logic            cpu_gnt;

    logic            bg_start;
    logic            bg_done;
    logic [7:0]      bg_rd_addr;
    logic            bg_draw;
    logic [7:0]      bg_x;
    logic [7:0]      bg_y;
    logic [1:0]      bg_color;

    logic            sp_start;
    logic            sp_done;
    logic [7:0]      sp_rd_addr;
    logic            sp_draw;
    logic [7:0]      sp_x;
    logic [7:0]      sp_y;
    logic [1:0]      sp_color;

    logic [7:0]      vram_rd_addr;
    logic            fb_we;
    logic [7:0]      fb_x;
    logic [7:0]      fb_y;
    logic [1:0]      fb_color;

    logic            busy;
    logic            frame_done;
    logic            overrun;
    logic [FC_W-1:0] frame_count;
    logic [OV_W-1:0] overrun_count;

    modport master (
        input  frame_start, sprites_en, cpu_req,
        input  bg_done, bg_rd_addr, bg_draw, bg_x, bg_y, bg_color,
        input  sp_done, sp_rd_addr, sp_draw, sp_x, sp_y, sp_color,
        output cpu_gnt, bg_start, sp_start,
        output vram_rd_addr, fb_we, fb_x, fb_y, fb_color,
        output busy, frame_done, overrun, frame_count, overrun_count
    );

    modport slave (
        output frame_start, sprites_en, cpu_req,
        output bg_done, bg_rd_addr, bg_draw, bg_x, bg_y, bg_color,
        output sp_done, sp_rd_addr, sp_draw, sp_x, sp_y, sp_color,
        input  cpu_gnt, bg_start, sp_start,
        input  vram_rd_addr, fb_we, fb_x, fb_y, fb_color,
        input  busy, frame_done, overrun, frame_count, overrun_count
    );
endinterface

// File: rtl/render_scheduler.sv
// Per-frame sequencer: background pass, optional sprite pass, CPU VRAM grant between frames,
// plus frame and dropped-frame counters.
module render_scheduler #(
    parameter int unsigned FC_W = 16,
    parameter int unsigned OV_W = 8
) (
    input logic                clk,
    input logic                reset,
    render_scheduler_if.master bus
);
    typedef enum logic [2:0] {Idle, Cpu, BgRun, BgRel, SpRun, SpRel} stateT;

    stateT           stateQ, stateD;
    logic            pendingQ, pendingD;
    logic            spEnQ, spEnD;
    logic            frameDoneQ, frameDoneD;
    logic            overrunQ, overrunD;
    logic [FC_W-1:0] frameCountQ;
    logic [OV_W-1:0] overrunCountQ;
    logic            rendering;

    assign rendering = (stateQ == BgRun) || (stateQ == BgRel) ||
                       (stateQ == SpRun) || (stateQ == SpRel);

    always_comb begin
        stateD     = stateQ;
        pendingD   = pendingQ;
        spEnD      = spEnQ;
        frameDoneD = 1'b0;
        // Any vblank arriving mid-render is dropped, never queued.
        overrunD   = rendering && bus.frame_start;
        unique case (stateQ)
            Idle: begin
                if (bus.frame_start || pendingQ) begin
                    stateD   = BgRun;
                    spEnD    = bus.sprites_en;
                    pendingD = 1'b0;
                end else if (bus.cpu_req) begin
                    stateD = Cpu;
                end
            end
            Cpu: begin
                // The CPU keeps VRAM; one vblank may wait, a second one is lost.
                if (bus.frame_start) begin
                    overrunD = pendingQ;
                    pendingD = 1'b1;
                end
                if (!bus.cpu_req) stateD = Idle;
            end
            BgRun: if (bus.bg_done) stateD = BgRel;
            BgRel: begin
                if (!bus.bg_done) begin
                    if (spEnQ) begin
                        stateD = SpRun;
                    end else begin
                        stateD     = Idle;
                        frameDoneD = 1'b1;
                    end
                end
            end
            SpRun: if (bus.sp_done) stateD = SpRel;
            SpRel: begin
                if (!bus.sp_done) begin
                    stateD     = Idle;
                    frameDoneD = 1'b1;
                end
            end
            default: stateD = Idle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ        <= Idle;
            pendingQ      <= 1'b0;
            spEnQ         <= 1'b0;
            frameDoneQ    <= 1'b0;
            overrunQ      <= 1'b0;
            frameCountQ   <= '0;
            overrunCountQ <= '0;
        end else begin
            stateQ     <= stateD;
            pendingQ   <= pendingD;
            spEnQ      <= spEnD;
            frameDoneQ <= frameDoneD;
            overrunQ   <= overrunD;
            if (frameDoneD) frameCountQ <= frameCountQ + FC_W'(1);
            if (overrunD && (overrunCountQ != '1)) overrunCountQ <= overrunCountQ + OV_W'(1);
        end
    end

    assign bus.cpu_gnt       = (stateQ == Cpu);
    assign bus.bg_start      = (stateQ == BgRun);
    assign bus.sp_start      = (stateQ == SpRun);
    assign bus.busy          = rendering;
    assign bus.frame_done    = frameDoneQ;
    assign bus.overrun       = overrunQ;
    assign bus.frame_count   = frameCountQ;
    assign bus.overrun_count = overrunCountQ;

    // Ports follow the owning engine through its release phase; idle/CPU drive zeros.
    always_comb begin
        bus.vram_rd_addr = '0;
        bus.fb_we        = 1'b0;
        bus.fb_x         = '0;
        bus.fb_y         = '0;
        bus.fb_color     = '0;
        unique case (stateQ)
            BgRun, BgRel: begin
                bus.vram_rd_addr = bus.bg_rd_addr;
                bus.fb_we        = bus.bg_draw;
                bus.fb_x         = bus.bg_x;
                bus.fb_y         = bus.bg_y;
                bus.fb_color     = bus.bg_color;
            end
            SpRun, SpRel: begin
                bus.vram_rd_addr = bus.sp_rd_addr;
                bus.fb_we        = bus.sp_draw;
                bus.fb_x         = bus.sp_x;
                bus.fb_y         = bus.sp_y;
                bus.fb_color     = bus.sp_color;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_render_scheduler.sv
// Self-checking bench for render_scheduler: scripted handshake engines, random pixel traffic,
// and a frame-level timeline model of the expected outputs.
module tb_render_scheduler;
    localparam int unsigned FC_W = 16;
    localparam int unsigned OV_W = 8;
    localparam int OV_MAX = (1 << OV_W) - 1;

    logic clk = 1'b0;
    logic reset;
    int errors = 0;
    int checks = 0;
    int expFrames = 0;
    int expOv = 0;

    always #5 clk = ~clk;

    render_scheduler_if #(.FC_W(FC_W), .OV_W(OV_W)) bus ();
    render_scheduler #(.FC_W(FC_W), .OV_W(OV_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic int sat_inc(input int v);
        return (v < OV_MAX) ? v + 1 : OV_MAX;
    endfunction

    function automatic logic [5:0] obs_ctrl();
        return {bus.bg_start, bus.sp_start, bus.busy, bus.cpu_gnt, bus.frame_done, bus.overrun};
    endfunction

    function automatic logic [26:0] obs_mux();
        return {bus.vram_rd_addr, bus.fb_we, bus.fb_x, bus.fb_y, bus.fb_color};
    endfunction

    // sel: 0 nobody owns the ports, 1 background, 2 sprites
    function automatic logic [26:0] mux_exp(input int sel);
        if (sel == 1) return {bus.bg_rd_addr, bus.bg_draw, bus.bg_x, bus.bg_y, bus.bg_color};
        if (sel == 2) return {bus.sp_rd_addr, bus.sp_draw, bus.sp_x, bus.sp_y, bus.sp_color};
        return '0;
    endfunction

    task automatic drive_pixels();
        bus.bg_rd_addr = 8'($urandom);
        bus.bg_draw    = 1'($urandom);
        bus.bg_x       = 8'($urandom);
        bus.bg_y       = 8'($urandom);
        bus.bg_color   = 2'($urandom);
        bus.sp_rd_addr = 8'($urandom);
        bus.sp_draw    = 1'($urandom);
        bus.sp_x       = 8'($urandom);
        bus.sp_y       = 8'($urandom);
        bus.sp_color   = 2'($urandom);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.frame_start = 1'b0;
        bus.sprites_en  = 1'b0;
        bus.cpu_req     = 1'b0;
        bus.bg_done     = 1'b0;
        bus.sp_done     = 1'b0;
        drive_pixels();
        next_cycle();
        next_cycle();
        checks++;
        if ({obs_ctrl(), obs_mux(), bus.frame_count, bus.overrun_count} !== 57'd0) begin
            errors++;
            $display("FAIL reset: outputs got %h want 0",
                     {obs_ctrl(), obs_mux(), bus.frame_count, bus.overrun_count});
        end
        reset = 1'b1;
        expFrames = 0;
        expOv = 0;
    endtask

    // Issue an accepted vblank from IDLE; returns in the first BG_RUN cycle.
    task automatic start_frame(input bit spEn);
        drive_pixels();
        bus.sprites_en  = spEn;
        bus.frame_start = 1'b1;
        next_cycle();
        bus.frame_start = 1'b0;
    endtask

    // Timeline of one frame: bgLen BG_RUN cycles, one BG_REL, spLen SP_RUN, one SP_REL, then an
    // IDLE cycle carrying frame_done. Extra vblanks are injected to provoke overruns.
    task automatic run_frame(input bit spEn, input int bgLen, input int spLen, input int ovBg,
                             input int ovSp, input bit ovRel, input string tag);
        int relLast;
        int sel;
        bit fs;
        bit fsPrev;
        bit inBg;
        bit inSp;
        bit idle;
        logic [5:0] ctrlExp;
        relLast = spEn ? bgLen + 1 + spLen : bgLen;
        fsPrev = 1'b0;
        for (int k = 0; k <= relLast + 1; k++) begin
            inBg = (k <= bgLen);
            inSp = spEn && (k > bgLen) && (k <= relLast);
            idle = (k == relLast + 1);
            drive_pixels();
            bus.sprites_en = 1'($urandom);
            bus.bg_done = (k == bgLen - 1);
            bus.sp_done = spEn && (k == relLast - 1);
            fs = (k < ovBg) || (spEn && (k > bgLen) && (k <= bgLen + ovSp)) ||
                 (ovRel && (k == relLast));
            bus.frame_start = fs;
            if (fs) expOv = sat_inc(expOv);
            if (idle) expFrames++;
            @(negedge clk);
            ctrlExp = {inBg && (k < bgLen), inSp && (k < relLast), !idle, 1'b0, idle, fsPrev};
            sel = idle ? 0 : (inBg ? 1 : 2);
            checks++;
            if (obs_ctrl() !== ctrlExp) begin
                errors++;
                $display("FAIL %s ctrl k=%0d: got %b want %b", tag, k, obs_ctrl(), ctrlExp);
            end
            checks++;
            if (obs_mux() !== mux_exp(sel)) begin
                errors++;
                $display("FAIL %s mux k=%0d: got %h want %h", tag, k, obs_mux(), mux_exp(sel));
            end
            if (idle) begin
                checks++;
                if (bus.frame_count !== FC_W'(expFrames)) begin
                    errors++;
                    $display("FAIL %s frame_count: got %0d want %0d", tag, bus.frame_count,
                             expFrames);
                end
                checks++;
                if (bus.overrun_count !== OV_W'(expOv)) begin
                    errors++;
                    $display("FAIL %s overrun_count: got %0d want %0d", tag, bus.overrun_count,
                             expOv);
                end
            end
            fsPrev = fs;
            next_cycle();
        end
        bus.frame_start = 1'b0;
        bus.bg_done = 1'b0;
        bus.sp_done = 1'b0;
    endtask

    task automatic test_frame_sprites();
        test_reset();
        start_frame(1'b1);
        run_frame(1'b1, 10, 10, 0, 0, 1'b0, "frame_sp");
        start_frame(1'b1);
        run_frame(1'b1, 1, 1, 0, 0, 1'b0, "frame_sp_min");
    endtask

    task automatic test_frame_no_sprites();
        test_reset();
        start_frame(1'b0);
        run_frame(1'b0, 10, 0, 0, 0, 1'b0, "frame_nosp");
    endtask

    // CPU holds VRAM for `hold` cycles; vblank at fsAt (and optionally a second one) waits.
    task automatic test_cpu(input int hold, input int fsAt, input int nFs, input bit spEn);
        int fs2;
        bit fs;
        bit fsPrev;
        logic [5:0] ctrlExp;
        fs2 = (nFs > 1) ? fsAt + int'($urandom_range(1, hold - 1 - fsAt)) : -10;
        fsPrev = 1'b0;
        for (int c = 0; c <= hold + 1; c++) begin
            drive_pixels();
            bus.cpu_req = (c < hold);
            fs = (c == fsAt) || (c == fs2);
            bus.frame_start = fs;
            bus.sprites_en = spEn;
            if (c == fs2) expOv = sat_inc(expOv);
            @(negedge clk);
            ctrlExp = {3'b000, (c >= 1) && (c <= hold), 1'b0, fsPrev && (c - 1 == fs2)};
            checks++;
            if (obs_ctrl() !== ctrlExp) begin
                errors++;
                $display("FAIL cpu ctrl c=%0d: got %b want %b", c, obs_ctrl(), ctrlExp);
            end
            checks++;
            if (obs_mux() !== 27'd0) begin
                errors++;
                $display("FAIL cpu mux c=%0d: got %h want 0", c, obs_mux());
            end
            fsPrev = fs;
            next_cycle();
        end
        bus.frame_start = 1'b0;
        run_frame(spEn, int'($urandom_range(2, 8)), int'($urandom_range(2, 8)), 0, 0, 1'b0,
                  "cpu_pending");
    endtask

    task automatic test_cpu_pending();
        test_reset();
        test_cpu(20, 5, 1, 1'b1);
        test_cpu(12, 3, 2, 1'b0);
    endtask

    task automatic test_simultaneous(input bit spEn);
        drive_pixels();
        bus.cpu_req = 1'b1;
        bus.frame_start = 1'b1;
        bus.sprites_en = spEn;
        next_cycle();
        bus.frame_start = 1'b0;
        run_frame(spEn, int'($urandom_range(2, 8)), int'($urandom_range(2, 8)), 0, 0, 1'b0,
                  "simul");
        drive_pixels();
        bus.cpu_req = 1'b0;
        @(negedge clk);
        checks++;
        if (obs_ctrl() !== 6'b000100) begin
            errors++;
            $display("FAIL simul gnt after frame: got %b want 000100", obs_ctrl());
        end
        next_cycle();
        @(negedge clk);
        checks++;
        if (obs_ctrl() !== 6'b000000) begin
            errors++;
            $display("FAIL simul gnt release: got %b want 000000", obs_ctrl());
        end
        next_cycle();
    endtask

    task automatic test_overrun();
        test_reset();
        start_frame(1'b1);
        run_frame(1'b1, int'($urandom_range(2, 6)), 8, 0, 3, 1'b0, "overrun");
        checks++;
        if (bus.overrun_count !== 8'd3) begin
            errors++;
            $display("FAIL overrun3: got %0d want 3", bus.overrun_count);
        end
        // Overrun on the release cycle lands on the same edge as frame_done.
        start_frame(1'b0);
        run_frame(1'b0, 4, 0, 0, 0, 1'b1, "overrun_done");
    endtask

    task automatic test_overrun_saturate();
        start_frame(1'b0);
        run_frame(1'b0, 305, 0, 300, 0, 1'b0, "ovsat");
        checks++;
        if (bus.overrun_count !== 8'hFF) begin
            errors++;
            $display("FAIL ovsat final: got %0d want 255", bus.overrun_count);
        end
    endtask

    task automatic test_reset_midframe();
        test_reset();
        for (int i = 0; i < 5; i++) begin
            start_frame(1'b1);
            run_frame(1'b1, int'($urandom_range(1, 4)), int'($urandom_range(1, 4)), 0, 0, 1'b0,
                      "pre_reset");
        end
        checks++;
        if (bus.frame_count !== 16'd5) begin
            errors++;
            $display("FAIL midreset precount: got %0d want 5", bus.frame_count);
        end
        start_frame(1'b1);
        bus.bg_done = 1'b1;
        next_cycle();
        bus.bg_done = 1'b0;
        next_cycle();
        drive_pixels();
        bus.sp_draw = 1'b1;
        bus.bg_draw = 1'b1;
        @(negedge clk);
        checks++;
        if ({obs_ctrl(), bus.fb_we} !== 7'b0110001) begin
            errors++;
            $display("FAIL midreset sprun: got %b want 0110001", {obs_ctrl(), bus.fb_we});
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({obs_ctrl(), obs_mux(), bus.frame_count, bus.overrun_count} !== 57'd0) begin
            errors++;
            $display("FAIL midreset async: got %h want 0",
                     {obs_ctrl(), obs_mux(), bus.frame_count, bus.overrun_count});
        end
        expFrames = 0;
        expOv = 0;
        next_cycle();
        next_cycle();
        reset = 1'b1;
        start_frame(1'b1);
        run_frame(1'b1, 6, 6, 0, 0, 1'b0, "post_reset");
    endtask

    task automatic test_random();
        int mode;
        int bgLen;
        int spLen;
        bit spEn;
        for (int it = 0; it < 14; it++) begin
            mode = int'($urandom_range(0, 2));
            spEn = 1'($urandom);
            bgLen = int'($urandom_range(1, 12));
            spLen = int'($urandom_range(1, 12));
            if (mode == 0) begin
                start_frame(spEn);
                run_frame(spEn, bgLen, spLen, int'($urandom_range(0, bgLen)),
                          int'($urandom_range(0, spLen)), 1'($urandom), "random");
            end else if (mode == 1) begin
                bgLen = int'($urandom_range(6, 25));
                test_cpu(bgLen, int'($urandom_range(1, bgLen - 2)), int'($urandom_range(1, 2)),
                         spEn);
            end else begin
                test_simultaneous(spEn);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        test_reset();
        test_frame_sprites();
        test_frame_no_sprites();
        test_cpu_pending();
        test_overrun();
        test_overrun_saturate();
        test_simultaneous(1'b1);
        test_reset_midframe();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/render_scheduler.md
# render_scheduler

Per-frame sequencer and shared-resource arbiter for the graphics pipeline. On each vblank pulse it runs the background engine, then the sprite engine (DrawSprites), through their start/done handshakes. It multiplexes the single VRAM read-address port and the VGA frame-buffer write port between the two engines, and grants VRAM to the CPU between frames. It also counts completed frames and dropped (overrun) frames.

## Interface
Parameters:
- FC_W, 16, width of frame counter
- OV_W, 8, width of saturating overrun counter

Ports:
- clk  in  1  system clock, all flops rising-edge
- reset  in  1  asynchronous, active-low (0 = reset asserted)
- frame_start  in  1  single-cycle vblank pulse
- sprites_en  in  1  sprite pass enable, sampled on accepted frame_start
- cpu_req  in  1  CPU requests VRAM, level
- cpu_gnt  out  1  CPU owns VRAM, level
- bg_start  out  1  background engine start, level
- bg_done  in  1  background engine done, level
- bg_rd_addr  in  8  background VRAM read address
- bg_draw, bg_x[8], bg_y[8], bg_color[2]  in  background pixel write
- sp_start  out  1  sprite engine start, level
- sp_done  in  1  sprite engine done, level
- sp_rd_addr  in  8  sprite VRAM read address
- sp_draw, sp_x[8], sp_y[8], sp_color[2]  in  sprite pixel write
- vram_rd_addr  out  8  muxed VRAM read address
- fb_we, fb_x[8], fb_y[8], fb_color[2]  out  muxed frame-buffer write
- busy  out  1  high in any render state
- frame_done  out  1  one-cycle pulse on frame completion
- overrun  out  1  one-cycle pulse when a frame_start is dropped
- frame_count  out  FC_W  completed frames, wraps
- overrun_count  out  OV_W  dropped frames, saturates at all-ones

## Operation
- States: IDLE, CPU, BG_RUN, BG_REL, SP_RUN, SP_REL.
- IDLE:
  - frame_start (or pending flag) -> BG_RUN; latch sprites_en into sp_en_q; clear pending.
  - Else if cpu_req -> CPU.
  - frame_start has priority over cpu_req.
- CPU: cpu_gnt=1.
  - frame_start sets pending.
  - A frame_start while pending is already set -> overrun.
  - cpu_req=0 -> IDLE.
  - The CPU is never preempted.
- BG_RUN: bg_start=1. bg_done=1 -> BG_REL.
- BG_REL: bg_start=0. Wait bg_done=0, then:
  - sp_en_q=1 -> SP_RUN.
  - sp_en_q=0 -> IDLE with frame_done.
- SP_RUN: sp_start=1. sp_done=1 -> SP_REL.
- SP_REL: sp_start=0. Wait sp_done=0, then -> IDLE with frame_done.
- frame_start in any render state (BG_RUN..SP_REL) -> overrun pulse, overrun_count+1 (saturating). The frame is dropped; nothing is queued.
- frame_done pulse and frame_count+1 (mod 2^FC_W) occur on the same clock edge as the transition to IDLE.
- Muxing is combinational, driven from the registered state:
  - BG_RUN/BG_REL: vram_rd_addr=bg_rd_addr; fb_*=bg_*.
  - SP_RUN/SP_REL: vram_rd_addr=sp_rd_addr; fb_*=sp_*.
  - IDLE/CPU: vram_rd_addr=0, fb_we=0, fb_x=fb_y=0, fb_color=0.
- fb_we is gated: it is only ever the active engine's draw. The inactive engine's draw is ignored.
- busy=1 in BG_RUN, BG_REL, SP_RUN, SP_REL.

## Timing
- Reset (reset=0):
  - Asynchronously forces state IDLE.
  - Clears pending, sp_en_q, frame_count, overrun_count.
  - All outputs read 0: bg_start, sp_start, cpu_gnt, busy, frame_done, overrun, fb_we, vram_rd_addr, fb_*.
- Reset mid-frame aborts immediately. Both starts drop, so the engines see start=0 and return to their own idle states.
- frame_start at edge N in IDLE: BG_RUN and bg_start=1 from cycle N+1.
- bg_done seen at edge M: bg_start=0 from M+1. When bg_done=0 is observed, sp_start=1 from the following cycle.
- cpu_req at edge N in IDLE with no frame_start: cpu_gnt=1 from N+1. cpu_req drop at edge K: cpu_gnt=0 from K+1.
- Pending frame after CPU release: the scheduler spends one cycle in IDLE, then enters BG_RUN.
- vram_rd_addr and fb_* have zero added latency versus the engine outputs. The engine's rd_data timing is unchanged.
- frame_start and cpu_req rising on the same edge in IDLE: the frame wins. cpu_gnt waits until the frame completes and the scheduler returns to IDLE.
- overrun and frame_done on the same edge are both asserted. The counters update independently.

## Test plan
- Reset, then one frame_start with sprites_en=1, engine models reporting done after 10 cycles -> bg_start high for 10 cycles, then sp_start high; frame_done pulse; frame_count=1; fb_we only mirrors the active engine's draw.
- sprites_en=0 at frame_start (toggled to 1 mid-frame) -> sp_start never asserts; frame_done after the BG_REL handshake; frame_count=1.
- cpu_req held 20 cycles, frame_start at cycle 5 -> cpu_gnt stays high for all 20 cycles; bg_start rises 2 cycles after cpu_req drops; overrun=0.
- Three frame_starts during SP_RUN -> three overrun pulses; overrun_count=3; frame_count increments once. Drive 300 overruns -> overrun_count=255.
- frame_start and cpu_req on the same cycle -> BG_RUN first; cpu_gnt=1 the cycle after return to IDLE.
- reset pulsed low mid-SP_RUN with frame_count=5 -> outputs 0 asynchronously; frame_count=0; next frame_start runs a full frame normally.
